// File: rtl/vote_tally_pkg.sv
// Shared types and constants for the vote-collection stage and the downstream
// winner-selection block.
package evm_pkg;

  localparam int NUM_CAND = 3;
  localparam int CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    CLOSED = 2'd2
  } poll_state_t;

  // Packed layout consumed as-is by the winner stage; slot 0 is the low nibble.
  typedef logic [NUM_CAND-1:0][CNT_W-1:0] cand_arr_t;

  function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 4'd1;
  endfunction

endpackage

// File: rtl/vote_tally_if.sv
// Officer controls, candidate buttons and tally results for one polling unit.
interface vote_tally_if;
  import evm_pkg::*;

  logic                start_i;
  logic                close_i;
  logic                ballot_en_i;
  logic [NUM_CAND-1:0] vote_btn_i;
  cand_arr_t           candidate_numbers;
  cand_arr_t           vote_counts;
  logic                results_valid;
  logic                ballot_ready;
  logic                vote_ack;
  logic                vote_err;
  logic                sat_flag;
  poll_state_t         state;

  // Handshake: a lone button edge is taken when ballot_ready is high, and
  // vote_ack is the one-cycle accept strobe; an edge offered while
  // ballot_ready is low (or together with another edge) yields vote_err.
  modport master (
    output start_i, close_i, ballot_en_i, vote_btn_i,
    input  candidate_numbers, vote_counts, results_valid, ballot_ready,
           vote_ack, vote_err, sat_flag, state
  );

  modport slave (
    input  start_i, close_i, ballot_en_i, vote_btn_i,
    output candidate_numbers, vote_counts, results_valid, ballot_ready,
           vote_ack, vote_err, sat_flag, state
  );
endinterface

// File: rtl/vote_tally_btn_sync_edge.sv
// Per-bit two-flop synchroniser followed by a rising-edge detector.
module btn_sync_edge #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);
  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
endmodule

// File: rtl/vote_tally.sv
// Poll session FSM and saturating per-candidate tallies.
// Build option EVM_BALLOT_LOCK_EN: one vote per officer-issued ballot.
module vote_tally
  import evm_pkg::*;
#(
  parameter logic [3:0] CAND0_NUM = 4'd1,
  parameter logic [3:0] CAND1_NUM = 4'd2,
  parameter logic [3:0] CAND2_NUM = 4'd3
) (
  input logic        clk,
  input logic        rst,
  vote_tally_if.slave bus
);
  poll_state_t         state_q, state_d;
  cand_arr_t           counts_q, counts_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                sat_q, sat_d;
  logic [NUM_CAND-1:0] edges;
  logic                ready;

  btn_sync_edge #(.W(NUM_CAND)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.vote_btn_i),
    .rise (edges)
  );

`ifdef EVM_BALLOT_LOCK_EN
  logic armed_q, armed_d;
  assign ready = (state_q == OPEN) && armed_q;
`else
  wire unused_ballot_en = bus.ballot_en_i;
  assign ready = (state_q == OPEN);
`endif

  always_comb begin
    state_d  = state_q;
    counts_d = counts_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    sat_d    = sat_q;
`ifdef EVM_BALLOT_LOCK_EN
    armed_d  = armed_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = OPEN;
`ifdef EVM_BALLOT_LOCK_EN
          armed_d = 1'b0;
`endif
        end
      end
      OPEN: begin
        // Closing takes priority: a coincident edge is dropped without error.
        if (bus.close_i) begin
          state_d = CLOSED;
        end else if (edges != '0) begin
          if (ready && is_onehot(edges)) begin
            ack_d = 1'b1;
            for (int i = 0; i < NUM_CAND; i++) begin
              if (edges[i]) begin
                counts_d[i] = sat_inc(counts_q[i]);
                if (counts_q[i] >= CNT_MAX - 4'd1) sat_d = 1'b1;
              end
            end
`ifdef EVM_BALLOT_LOCK_EN
            armed_d = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
`ifdef EVM_BALLOT_LOCK_EN
        if (bus.ballot_en_i) armed_d = 1'b1;
`endif
      end
      CLOSED: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      counts_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      sat_q    <= 1'b0;
`ifdef EVM_BALLOT_LOCK_EN
      armed_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      counts_q <= counts_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      sat_q    <= sat_d;
`ifdef EVM_BALLOT_LOCK_EN
      armed_q  <= armed_d;
`endif
    end
  end

  assign bus.candidate_numbers = {CAND2_NUM, CAND1_NUM, CAND0_NUM};
  assign bus.vote_counts       = counts_q;
  assign bus.results_valid     = (state_q == CLOSED);
  assign bus.ballot_ready      = ready;
  assign bus.vote_ack          = ack_q;
  assign bus.vote_err          = err_q;
  assign bus.sat_flag          = sat_q;
  assign bus.state             = state_q;
endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally: expected tallies are queued as votes are
// driven and checked against each vote_ack by a negedge monitor.
module tb_vote_tally;
  import evm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vote_tally_if bus();

  vote_tally dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_seen = 0;
  int err_seen = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each vote_ack retires one {slot, expected count} entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.vote_ack === 1'b1) begin
        ack_seen++;
        if (exp_q.size() == 0) begin
          check("ack_unexpected", exp_q.size(), 1);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          check("sb_count", bus.vote_counts[e[5:4]], e[3:0]);
        end
      end
      if (bus.vote_err === 1'b1) err_seen++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ballot();
    bus.ballot_en_i = 1'b1;
    cyc();
    bus.ballot_en_i = 1'b0;
  endtask

  task automatic press(input logic [2:0] b);
    bus.vote_btn_i = b;
    cyc();
    cyc();
    bus.vote_btn_i = '0;
    cyc();
    cyc();
    cyc();
  endtask

  task automatic vote(input logic [1:0] slot, input logic [3:0] exp_cnt);
    ballot();
    exp_q.push_back({slot, exp_cnt});
    press(3'b001 << slot);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic open_poll();
    bus.start_i = 1'b1;
    cyc();
    bus.start_i = 1'b0;
  endtask

  int a0, e0;

  initial begin
    bus.start_i = 1'b0;
    bus.close_i = 1'b0;
    bus.ballot_en_i = 1'b0;
    bus.vote_btn_i = '0;
    cyc();
    cyc();
    @(negedge clk);
    check("rst_counts", bus.vote_counts, 12'h000);
    check("rst_state", bus.state, IDLE);
    check("rst_flags", {bus.results_valid, bus.ballot_ready, bus.vote_ack, bus.vote_err, bus.sat_flag}, 5'b0);
    check("cand_nums", bus.candidate_numbers, 12'h321);
    @(posedge clk); #1;
    rst = 1'b0;

    // Start ignored-close check, then open.
    bus.close_i = 1'b1;
    cyc();
    bus.close_i = 1'b0;
    @(negedge clk);
    check("idle_close_ignored", bus.state, IDLE);
    @(posedge clk); #1;
    open_poll();
    @(negedge clk);
    check("open_state", bus.state, OPEN);
`ifdef EVM_BALLOT_LOCK_EN
    check("lock_not_ready", bus.ballot_ready, 1'b0);
    a0 = ack_seen; e0 = err_seen;
    @(posedge clk); #1;
    press(3'b001);
    press(3'b001);
    ballot();
    @(negedge clk);
    check("lock_ready", bus.ballot_ready, 1'b1);
    @(posedge clk); #1;
    exp_q.push_back({2'd0, 4'd1});
    press(3'b001);
    press(3'b001);
    check("lock_count0", bus.vote_counts[0], 4'd1);
    check("lock_errs", err_seen - e0, 3);
    check("lock_acks", ack_seen - a0, 1);
    do_reset();
    open_poll();
`else
    check("ready_no_ballot", bus.ballot_ready, 1'b1);
    @(posedge clk); #1;
`endif

    // Button1 held five cycles: one vote, ack exactly two edges after sampling.
    a0 = ack_seen; e0 = err_seen;
    ballot();
    bus.vote_btn_i = 3'b010;
    exp_q.push_back({2'd1, 4'd1});
    @(posedge clk); @(negedge clk);
    check("lat_k", bus.vote_ack, 1'b0);
    @(posedge clk); @(negedge clk);
    check("lat_k1", bus.vote_ack, 1'b0);
    @(posedge clk); @(negedge clk);
    check("lat_k2_ack", bus.vote_ack, 1'b1);
    check("lat_k2_cnt", bus.vote_counts[1], 4'd1);
    @(posedge clk); @(posedge clk); #1;
    bus.vote_btn_i = '0;
    cyc(); cyc(); cyc();
    check("held_counts", bus.vote_counts, 12'h010);
    check("held_acks", ack_seen - a0, 1);
    check("held_no_err", err_seen - e0, 0);

    // Simultaneous edges on buttons 0 and 2.
    a0 = ack_seen; e0 = err_seen;
    ballot();
    press(3'b101);
    check("multi_counts", bus.vote_counts, 12'h010);
    check("multi_err", err_seen - e0, 1);
    check("multi_no_ack", ack_seen - a0, 0);

    // Seventeen presses of button2 saturate at 15.
    a0 = ack_seen;
    check("sat_before", bus.sat_flag, 1'b0);
    for (int i = 1; i <= 17; i++) vote(2'd2, (i > 15) ? 4'd15 : 4'(i));
    check("sat_count2", bus.vote_counts[2], 4'd15);
    check("sat_flag", bus.sat_flag, 1'b1);
    check("sat_acks", ack_seen - a0, 17);

    // Button0 edge coincident with close: close wins.
    a0 = ack_seen; e0 = err_seen;
    ballot();
    bus.vote_btn_i = 3'b001;
    cyc(); cyc();
    @(negedge clk);
    check("close_rv_before", bus.results_valid, 1'b0);
    bus.close_i = 1'b1;
    @(posedge clk); #1;
    bus.close_i = 1'b0;
    bus.vote_btn_i = '0;
    @(negedge clk);
    check("close_rv", bus.results_valid, 1'b1);
    check("close_state", bus.state, CLOSED);
    check("close_count0", bus.vote_counts[0], 4'd0);
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    ballot();
    bus.start_i = 1'b0;
    press(3'b010);
    press(3'b001);
    check("closed_frozen", bus.vote_counts, 12'hF10);
    check("closed_still", bus.state, CLOSED);
    check("closed_no_ack", ack_seen - a0, 0);
    check("closed_no_err", err_seen - e0, 0);

    // Build counts {3,2,1}, then reset mid-poll with a vote and close pending.
    do_reset();
    open_poll();
    vote(2'd0, 4'd1);
    vote(2'd1, 4'd1);
    vote(2'd1, 4'd2);
    vote(2'd2, 4'd1);
    vote(2'd2, 4'd2);
    vote(2'd2, 4'd3);
    check("pre_rst_counts", bus.vote_counts, 12'h321);
    ballot();
    bus.vote_btn_i = 3'b001;
    cyc(); cyc();
    rst = 1'b1;
    bus.close_i = 1'b1;
    cyc();
    rst = 1'b0;
    bus.close_i = 1'b0;
    bus.vote_btn_i = '0;
    @(negedge clk);
    check("mid_rst_counts", bus.vote_counts, 12'h000);
    check("mid_rst_state", bus.state, IDLE);
    check("mid_rst_flags", {bus.results_valid, bus.ballot_ready, bus.vote_ack, bus.vote_err, bus.sat_flag}, 5'b0);
    @(posedge clk); #1;
    cyc(); cyc();
    check("mid_rst_stays", bus.vote_counts, 12'h000);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vote_tally.md
# vote_tally

Sequential vote-collection stage directly upstream of the winner-selection combinational block. It synchronises and edge-detects three candidate push-buttons, runs the poll session state machine, and accumulates one 4-bit saturating count per candidate. It presents `vote_counts` and `candidate_numbers` in the exact packed layout the winner stage consumes, plus a `results_valid` qualifier.

## Interface
Parameters:
- `CAND0_NUM`, default 4'd1: candidate number reported in slot 0.
- `CAND1_NUM`, default 4'd2: candidate number reported in slot 1.
- `CAND2_NUM`, default 4'd3: candidate number reported in slot 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  officer opens the poll (level, sampled).
- `close_i`  in  1  officer closes the poll (level, sampled).
- `ballot_en_i`  in  1  officer issues one ballot. Used only with lockout compiled in.
- `vote_btn_i`  in  3  asynchronous candidate buttons; bit i maps to slot i.
- `candidate_numbers`  out  [2:0][3:0]  constant {CAND2_NUM, CAND1_NUM, CAND0_NUM}.
- `vote_counts`  out  [2:0][3:0]  per-slot tallies.
- `results_valid`  out  1  high only in CLOSED.
- `ballot_ready`  out  1  a vote will currently be accepted.
- `vote_ack`  out  1  one-cycle pulse when a vote is counted.
- `vote_err`  out  1  one-cycle pulse when a button edge is rejected.
- `sat_flag`  out  1  sticky; set when any slot hits 15.

## Operation
- Buttons pass through a 2-flop synchroniser, then a rising-edge detector (`sync2 & ~prev`).
- The FSM has three states: IDLE, OPEN, CLOSED. Transitions:
  - IDLE → OPEN on `start_i`. `close_i` is ignored in IDLE.
  - OPEN → CLOSED on `close_i`. `start_i` is ignored in OPEN.
  - CLOSED is terminal. Only `rst` leaves it.
- A vote is accepted only when all of the following hold in the same cycle:
  - state is OPEN;
  - `ballot_ready` is 1;
  - exactly one edge bit is set;
  - `close_i` is 0.
- On acceptance the selected slot increments and `vote_ack` pulses.
- Rejection cases:
  - Two or more simultaneous edges: nothing counted, `vote_err` pulses.
  - Edge in OPEN while `ballot_ready` is 0: `vote_err` pulses.
  - Edges in IDLE or CLOSED: ignored silently.
- `close_i` coincident with a valid edge: close wins, the vote is discarded, no `vote_ack`.
- Counts saturate at 4'd15. An increment at 15 holds 15, still pulses `vote_ack`, and sets `sat_flag`.
- Holding a button produces exactly one edge, so it counts once.
- Counts freeze in CLOSED.

## Timing
- Reset values:
  - FSM in IDLE;
  - all counts 0;
  - synchroniser and edge flops 0;
  - `results_valid`, `ballot_ready`, `vote_ack`, `vote_err`, `sat_flag` all 0.
- `candidate_numbers` is constant and not registered.
- Vote latency: a button first sampled high at edge k updates `vote_counts` and asserts `vote_ack` registered at edge k+2.
- `vote_ack` and `vote_err` are registered and last exactly one cycle.
- `results_valid` rises the cycle after the edge that samples `close_i` in OPEN.
- `rst` mid-poll wins over everything, including a vote or close in the same cycle.

## Configuration
- Macro `EVM_BALLOT_LOCK_EN`.
- Defined:
  - OPEN gains a one-bit `armed` register, cleared on entry to OPEN.
  - `ballot_en_i` high sets `armed`.
  - An accepted vote clears `armed`.
  - `ballot_ready = OPEN & armed`.
  - If `ballot_en_i` and an accepted vote fall in the same cycle, `armed` ends set (a new ballot is issued).
- Undefined:
  - `ballot_en_i` is ignored.
  - `ballot_ready = (state == OPEN)`.
  - Every single valid edge counts.

## Structure
- Shared package `evm_pkg`:
  - `NUM_CAND = 3`;
  - `CNT_W = 4`;
  - `CNT_MAX = 4'd15`;
  - poll-state enum `poll_state_t` {IDLE, OPEN, CLOSED};
  - the `cand_arr_t` packed type `[2:0][3:0]`, shared with the winner stage.
- One natural sub-module: `btn_sync_edge`, a per-bit 2-flop synchroniser plus rising-edge detector, instantiated with width `NUM_CAND`.

## Test plan
- Reset, `start_i` pulse, then button1 held 5 cycles → `vote_counts[1]=1`, one `vote_ack` at k+2, `vote_err` never high.
- OPEN, buttons 0 and 2 rise in the same cycle → counts unchanged, one `vote_err` pulse.
- OPEN, 17 separate presses of button2 → `vote_counts[2]=15`, `sat_flag=1`, 17 `vote_ack` pulses.
- Button0 edge arriving in the same cycle as `close_i` → count 0 unchanged, `results_valid=1` next cycle; later presses are ignored.
- With `EVM_BALLOT_LOCK_EN`: two button0 presses with no ballot, then `ballot_en_i`, then two presses → `vote_counts[0]=1`, three `vote_err` pulses, one `vote_ack`.
- `rst` asserted in OPEN with counts {3,2,1} → next cycle all counts 0, state IDLE, all flags 0.
